// File: rtl/rgb_msg_sequencer_if.sv
// Host-side bundle for rgb_msg_sequencer: buffer write port, playback control and LED drive.
// The master modport is the host/user logic; the slave modport is the sequencer.
interface rgb_msg_sequencer_if #(
   parameter int MAX_LEN  = 16,
   parameter int PWM_BITS = 8
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LW = $clog2(MAX_LEN + 1);

   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [7:0]          wr_data;
   logic [LW-1:0]       msg_len;
   logic                loop;
   logic                start;
   logic                stop;
   logic [PWM_BITS-1:0] brightness;
   logic                red;
   logic                green;
   logic                blue;
   logic                busy;
   logic                done;
   logic [AW-1:0]       char_idx;

   modport master (
      output wr_en, wr_addr, wr_data, msg_len, loop, start, stop, brightness,
      input  red, green, blue, busy, done, char_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, msg_len, loop, start, stop, brightness,
      output red, green, blue, busy, done, char_idx
   );
endinterface

// File: rtl/rgb_msg_sequencer.sv
// Plays a host-loaded character buffer out as RGB colours, one symbol per SYMBOL_CYCLES clocks.
// Optional brightness PWM is enabled by defining RGB_SEQ_PWM_EN.
module rgb_msg_sequencer #(
   parameter int MAX_LEN       = 16,
   parameter int SYMBOL_CYCLES = 48_000_000,
   parameter int GAP_CYCLES    = 0,
   parameter int PWM_BITS      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rgb_msg_sequencer_if.slave   bus
);
   localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LW   = $clog2(MAX_LEN + 1);
   localparam int MAXC = (SYMBOL_CYCLES > GAP_CYCLES) ? SYMBOL_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] last_q, last_d;
   logic          loop_q, loop_d;
   logic          done_q, done_d;
   logic          adv;
   logic [LW-1:0] len_clamped;

   logic [7:0]    buf_mem [MAX_LEN];
   logic [7:0]    rd_char_q;
   logic [2:0]    colour;
   logic          wr_ok;
   logic          pwm_on;

   assign wr_ok = bus.wr_en && (state_q == IDLE) && (32'(bus.wr_addr) < 32'(MAX_LEN));

   // Registered read addressed by the next index, so the character is ready on state entry.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         buf_mem[bus.wr_addr] <= bus.wr_data;
      end
      rd_char_q <= buf_mem[idx_d];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      last_d      = last_q;
      loop_d      = loop_q;
      done_d      = 1'b0;
      adv         = 1'b0;
      len_clamped = (bus.msg_len > MAX_LEN_L) ? MAX_LEN_L : bus.msg_len;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.start && !bus.stop && (bus.msg_len != '0)) begin
               state_d = SHOW;
               idx_d   = '0;
               last_d  = AW'(len_clamped - 1'b1);
               loop_d  = bus.loop;
            end
         end
         SHOW: begin
            if (cnt_q == SYM_LAST) begin
               cnt_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               adv   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (adv) begin
         if (idx_q != last_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = SHOW;
         end else if (loop_q) begin
            idx_d   = '0;
            state_d = SHOW;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end

      // Abort overrides any advance or completion decided above.
      if ((state_q != IDLE) && bus.stop) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = idx_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      colour = 3'b000;
      case (rd_char_q)
         "A":     colour = 3'b100;
         "B":     colour = 3'b010;
         "C":     colour = 3'b001;
         "D":     colour = 3'b101;
         "E":     colour = 3'b110;
         "F":     colour = 3'b011;
         " ":     colour = 3'b111;
         default: colour = 3'b000;
      endcase
   end

`ifdef RGB_SEQ_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

   assign pwm_cnt_d = pwm_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   assign pwm_on = (pwm_cnt_q < bus.brightness) || (&bus.brightness);
`else
   logic unused_brightness;
   assign unused_brightness = ^bus.brightness;
   assign pwm_on            = 1'b1;
`endif

   assign bus.red      = (state_q == SHOW) && colour[2] && pwm_on;
   assign bus.green    = (state_q == SHOW) && colour[1] && pwm_on;
   assign bus.blue     = (state_q == SHOW) && colour[0] && pwm_on;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.char_idx = idx_q;
endmodule

// File: tb/tb_rgb_msg_sequencer.sv
// Self-checking bench: two sequencers (no gap / 2-clock gap) driven from one vector table,
// per-cycle expectations queued at start and popped as the DUT plays.
module tb_rgb_msg_sequencer;
   localparam int ML = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sel;
   logic       wr_en, loop, start, stop;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] msg_len;
   logic [7:0] brightness;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   rgb_msg_sequencer_if #(.MAX_LEN(ML), .PWM_BITS(8)) bus_a ();
   rgb_msg_sequencer_if #(.MAX_LEN(ML), .PWM_BITS(8)) bus_b ();

   assign bus_a.wr_en      = wr_en;
   assign bus_a.wr_addr    = wr_addr;
   assign bus_a.wr_data    = wr_data;
   assign bus_a.msg_len    = msg_len;
   assign bus_a.loop       = loop;
   assign bus_a.start      = start & ~sel;
   assign bus_a.stop       = stop;
   assign bus_a.brightness = brightness;
   assign bus_b.wr_en      = wr_en;
   assign bus_b.wr_addr    = wr_addr;
   assign bus_b.wr_data    = wr_data;
   assign bus_b.msg_len    = msg_len;
   assign bus_b.loop       = loop;
   assign bus_b.start      = start & sel;
   assign bus_b.stop       = stop;
   assign bus_b.brightness = brightness;

   rgb_msg_sequencer #(.MAX_LEN(ML), .SYMBOL_CYCLES(4), .GAP_CYCLES(0), .PWM_BITS(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   rgb_msg_sequencer #(.MAX_LEN(ML), .SYMBOL_CYCLES(4), .GAP_CYCLES(2), .PWM_BITS(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct packed {
      logic       stop_pre;
      logic [2:0] rgb;
      logic       busy;
      logic       done;
      logic [1:0] idx;
   } exp_t;

   typedef struct {
      int          inst;
      logic [31:0] chars;
      logic        do_write;
      logic [2:0]  len;
      logic        lp;
      logic [11:0] exp_rgb;
      int          n_sym;
      int          run;
      logic        hold;
      logic        wr_during;
      string       name;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input exp_t e, input string nm);
      logic [4:0] act;
      logic [4:0] want;
      logic [1:0] aidx;
      act  = sel ? {bus_b.red, bus_b.green, bus_b.blue, bus_b.busy, bus_b.done}
                 : {bus_a.red, bus_a.green, bus_a.blue, bus_a.busy, bus_a.done};
      aidx = sel ? bus_b.char_idx : bus_a.char_idx;
      want = {e.rgb, e.busy, e.done};
      checks++;
      if (act !== want || (e.busy && aidx !== e.idx))
         $display("FAIL %s @%0t: rgb_busy_done=%b idx=%0d, expected %b idx=%0d",
                  nm, $time, act, aidx, want, e.idx);
      else
         passes++;
   endtask

   task automatic build(input vec_t v);
      int cyc = 0;
      int k   = 0;
      int gap = (v.inst != 0) ? 2 : 0;
      bit fin = 0;
      exp_t e;
      exp_q.delete();
      while (!fin && cyc < 2000) begin
         for (int s = 0; s < 4 + gap; s++) begin
            if (v.run != 0 && cyc == v.run) begin
               fin = 1;
               break;
            end
            e = '{1'b0, (s < 4) ? v.exp_rgb[11-3*k -: 3] : 3'b000, 1'b1, 1'b0, 2'(k)};
            exp_q.push_back(e);
            cyc++;
         end
         if (!fin) begin
            k++;
            if (k == v.n_sym) begin
               if (v.lp) k = 0;
               else fin = 1;
            end
         end
      end
      if (v.run != 0) exp_q.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2'd0});
      else            exp_q.push_back('{1'b0, 3'b000, 1'b0, 1'b1, 2'd0});
      exp_q.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 2'd0});
   endtask

   task automatic run_vec(input vec_t v, input int n);
      exp_t e;
      sel = (v.inst != 0);
      if (v.do_write) begin
         for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = v.chars[31-8*i -: 8];
            tick();
         end
      end
      wr_en = 1'b0;
      build(v);
      msg_len = v.len;
      loop    = v.lp;
      start   = 1'b1;
      tick();
      start = v.hold;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e, v.name);
         start   = v.hold & e.busy;
         wr_en   = v.wr_during & e.busy;
         wr_addr = 2'd0;
         wr_data = "C";
         stop    = (exp_q.size() > 0) && exp_q[0].stop_pre;
         if (exp_q.size() > 0) tick();
      end
      stop  = 1'b0;
      wr_en = 1'b0;
      start = 1'b0;
      $display("vec %0d %s: inst=%0d len=%0d loop=%0b", n, v.name, v.inst, v.len, v.lp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   r_cnt;
      int   gb_cnt;
      int   r_exp;
      exp_t idle_e;
      exp_t show_a;

      rst_n = 1'b0; sel = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      msg_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; brightness = 8'hFF;
      idle_e = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0};
      repeat (3) tick();
      sel = 1'b0; check(idle_e, "reset_a");
      sel = 1'b1; check(idle_e, "reset_b");
      checks++;
      if (bus_a.char_idx !== 2'd0 || bus_b.char_idx !== 2'd0)
         $display("FAIL reset_idx: got %0d/%0d, expected 0/0", bus_a.char_idx, bus_b.char_idx);
      else
         passes++;
      rst_n = 1'b1;
      tick();

      vecs[0] = '{0, "ABC ", 1'b1, 3'd3, 1'b0, 12'b100_010_001_000, 3, 0,  1'b0, 1'b0, "abc_oneshot"};
      vecs[1] = '{0, "DEF ", 1'b1, 3'd5, 1'b0, 12'b101_110_011_111, 4, 0,  1'b0, 1'b0, "len_clamp"};
      vecs[2] = '{0, "Z???", 1'b1, 3'd1, 1'b0, 12'b000_000_000_000, 1, 0,  1'b1, 1'b0, "off_hold_start"};
      vecs[3] = '{1, "D AA", 1'b1, 3'd2, 1'b1, 12'b101_111_000_000, 2, 28, 1'b0, 1'b0, "gap_loop_wrap"};
      vecs[4] = '{1, "AB??", 1'b1, 3'd2, 1'b0, 12'b100_010_000_000, 2, 0,  1'b0, 1'b0, "gap_oneshot"};
      vecs[5] = '{0, "BA??", 1'b1, 3'd2, 1'b1, 12'b010_100_000_000, 2, 6,  1'b0, 1'b1, "stop_mid_wr"};
      vecs[6] = '{0, "????", 1'b0, 3'd1, 1'b0, 12'b010_000_000_000, 1, 0,  1'b0, 1'b0, "buf_kept"};
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // msg_len = 0 and start+stop together must both leave the block idle.
      sel = 1'b0;
      msg_len = 3'd0; start = 1'b1; tick(); start = 1'b0;
      check(idle_e, "len0_start");
      tick();
      check(idle_e, "len0_start_hold");
      msg_len = 3'd1; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check(idle_e, "start_stop_same");
      $display("seq idle_starts: checked");

      // Brightness 64 over 512 clocks of a looping 'A'.
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = "A"; tick(); wr_en = 1'b0;
      brightness = 8'd64; msg_len = 3'd1; loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
      r_cnt = 0; gb_cnt = 0;
      for (int c = 0; c < 512; c++) begin
         r_cnt  += int'(bus_a.red);
         gb_cnt += int'(bus_a.green | bus_a.blue);
         tick();
      end
`ifdef RGB_SEQ_PWM_EN
      r_exp = 128;
`else
      r_exp = 512;
`endif
      checks++;
      if (r_cnt != r_exp) $display("FAIL pwm_red: high %0d clocks, expected %0d", r_cnt, r_exp);
      else passes++;
      checks++;
      if (gb_cnt != 0) $display("FAIL pwm_gb: high %0d clocks, expected 0", gb_cnt);
      else passes++;
      stop = 1'b1; tick(); stop = 1'b0;
      check(idle_e, "pwm_stop");
      brightness = 8'hFF;
      $display("seq pwm: red=%0d gb=%0d", r_cnt, gb_cnt);

      // Asynchronous reset between clock edges during playback.
      msg_len = 3'd2; loop = 1'b1; start = 1'b1; tick(); start = 1'b0; tick();
      show_a = '{1'b0, 3'b100, 1'b1, 1'b0, 2'd0};
      check(show_a, "pre_reset_show");
      #2 rst_n = 1'b0;
      #1 check(idle_e, "async_reset");
      tick();
      rst_n = 1'b1;
      tick();
      check(idle_e, "post_reset_idle");
      $display("seq async_reset: checked");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/rgb_msg_sequencer.md
# rgb_msg_sequencer

Parametrised message-to-colour sequencer for the tri-colour LED path. A host-loaded character buffer of up to `MAX_LEN` symbols is played out one symbol per `SYMBOL_CYCLES` clocks, with each character decoded to an RGB colour. Playback supports an optional blank gap, one-shot or looping mode, start/stop control and per-frame brightness. The block sits between user logic and the `SB_RGBA_DRV` PWM inputs, replacing a hard-coded message counter.

## Interface
Parameters:
- `MAX_LEN`, 16: buffer depth in characters (≥1).
- `SYMBOL_CYCLES`, 48_000_000: clocks each symbol is shown (≥1).
- `GAP_CYCLES`, 0: blank clocks after each symbol; 0 means no gap.
- `PWM_BITS`, 8: brightness/PWM resolution.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, from the global buffer.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(MAX_LEN)  write index.
- `wr_data`  in  8  ASCII character.
- `msg_len`  in  $clog2(MAX_LEN+1)  characters to play; sampled at start.
- `loop`  in  1  1 = repeat forever; sampled at start.
- `start`  in  1  start pulse.
- `stop`  in  1  abort pulse.
- `brightness`  in  PWM_BITS  duty level.
- `red`, `green`, `blue`  out  1 each  LED PWM drive.
- `busy`  out  1  playback active.
- `done`  out  1  one-cycle pulse at end of one-shot playback.
- `char_idx`  out  $clog2(MAX_LEN)  index currently shown.

## Operation
- States: IDLE, SHOW, GAP.
- IDLE:
  - `wr_en` writes `wr_data` to `buf[wr_addr]`.
  - Writes are ignored outside IDLE.
  - `wr_addr` ≥ MAX_LEN is ignored.
- Start (IDLE only):
  - `start` with `msg_len` ≠ 0 latches `len` = min(`msg_len`, MAX_LEN) and `loop`, sets `char_idx`=0, and enters SHOW.
  - `start` with `msg_len`=0 is ignored.
  - `start` outside IDLE is ignored.
- SHOW: colour = decode(`buf[char_idx]`), held for exactly SYMBOL_CYCLES clocks.
- After SHOW: enter GAP if GAP_CYCLES > 0; otherwise advance.
- GAP: colour = off for GAP_CYCLES clocks, then advance.
- Advance:
  - If `char_idx` < len−1: increment and enter SHOW.
  - Last index with loop=1: wrap to 0 and enter SHOW.
  - Last index with loop=0: pulse `done` and enter IDLE.
- Decode:
  - 'A' = R, 'B' = G, 'C' = B.
  - 'D' = R+B, 'E' = R+G, 'F' = G+B.
  - ' ' = R+G+B.
  - Any other character = off.
- Stop:
  - `stop` in SHOW/GAP enters IDLE on the next edge, forces colour off, and does not pulse `done`.
  - `stop` has priority over a same-cycle advance.
  - `stop` in IDLE has no effect.
  - Simultaneous `start` and `stop` in IDLE: `stop` wins, so the block stays IDLE.
- `busy` = 1 in SHOW and GAP.
- Counters: the symbol/gap counter is wide enough for max(SYMBOL_CYCLES, GAP_CYCLES) and reloads to 0 on every state entry.

## Timing
- Reset values:
  - State = IDLE.
  - `red`/`green`/`blue`/`busy`/`done` = 0.
  - `char_idx` = 0.
  - Counters = 0.
  - Buffer contents are not reset; reading one before it is written is undefined.
- Start latency: `start` high at edge N gives SHOW with valid colour and `busy`=1 after edge N.
- Symbol duration: index k is held exactly SYMBOL_CYCLES clocks, followed by GAP_CYCLES off clocks.
- One-shot total: len × (SYMBOL_CYCLES + GAP_CYCLES) clocks from start to IDLE.
- `done` is registered and asserted in the first IDLE cycle.
- Reset asserted mid-playback: all outputs are 0 immediately (asynchronous), and state returns to IDLE.

## Configuration
- `RGB_SEQ_PWM_EN` defined:
  - A free-running PWM_BITS counter `pwm_cnt` runs from reset.
  - Each channel = colour_bit AND (`pwm_cnt` < `brightness`).
  - `brightness` all-ones forces the channel fully on.
  - `brightness`=0 forces it off.
- `RGB_SEQ_PWM_EN` undefined:
  - No PWM counter.
  - Channel = colour_bit directly.
  - `brightness` is ignored.

## Test plan
- Reset, then start with `buf`="ABC", len=3, loop=0, SYMBOL_CYCLES=4, GAP_CYCLES=0 -> R for 4 clocks, then G for 4, then B for 4; `done` pulses at clock 13 after start; `busy` falls at the same time.
- GAP_CYCLES=2, `buf`="D ", loop=1 -> R+B for 4 clocks, off 2, white 4, off 2, then R+B again with `char_idx` wrapped to 0; `done` never pulses.
- `stop` asserted in cycle 2 of the second symbol -> next edge gives IDLE, LEDs off, `busy`=0, no `done`; a `wr_en` issued during playback leaves the buffer unchanged.
- `msg_len`=0 with `start` -> stays IDLE; `msg_len`=MAX_LEN+1 -> plays exactly MAX_LEN symbols.
- `buf`="Z" -> all channels 0 for SYMBOL_CYCLES; `start` held high through playback does not restart.
- With `RGB_SEQ_PWM_EN`, PWM_BITS=8, `brightness`=64, symbol 'A' -> `red` high for 64 of each 256 clocks, `green`/`blue` 0.
- Without `RGB_SEQ_PWM_EN`, same stimulus -> `red` constantly 1.
